wb_seq_read_master: RTL and testbench

// Wishbone classic initiator that issues sequential single-word reads on the user-area slave bus
// (e.g. the SDRAM controller window at 0x3800_0000) and streams returned words out through an

---
 rtl/wb_seq_read_master.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_seq_read_master.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_seq_read_master.sv
// wb_seq_read_master
// ------------------
// Wishbone classic read initiator. One command asks for cmd_len 32-bit words.
// They are read from consecutive word addresses starting at cmd_addr, with
// address bits [1:0] forced to zero. Each returned word goes into a small
// internal FIFO, and a consumer drains the FIFO through a valid/ready port.
//
// At most one read is ever outstanding. Between two reads the bus always
// returns to idle for at least one cycle. A read is only started when the
// FIFO has a free entry, so the FIFO cannot overflow.
//
// Handshake rule, used by both the command port and the read-data port:
// a transfer happens on a rising clk edge where valid and ready are both 1.
// valid does not depend on ready. The producer keeps its payload stable
// while it waits for ready.
//
// Parameters
//   FIFO_DEPTH  read-data FIFO entries (power of 2, >= 2)
//   LEN_W       width of cmd_len
//   TIMEOUT     REQ cycles allowed without ack before the command aborts (>= 1)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_ready is 1 only in IDLE
//   cmd_addr, cmd_len start byte address and word count
//   wbm_*             Wishbone classic master signals (read only)
//   rd_valid/ready    read-data handshake; rd_valid means the FIFO is not empty
//   rd_data           word at the FIFO head
//   busy              1 whenever the FSM is not in IDLE
//   done              one-cycle pulse when a command completes normally
//   err               one-cycle pulse when a command is aborted by timeout
//   state_dbg         current FSM state encoding, for observation
module wb_seq_read_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  // The wait counter only needs to reach TIMEOUT-1. That value marks the
  // last REQ cycle in which an ack is still accepted.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]       addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  logic              accept;
  logic              timeout;
  logic              push;
  logic              pop;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    timeout   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (rem_q == '0) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (count < DEPTH_C) begin
          // Uses the registered count. A pop in this same cycle is seen
          // one cycle later, so a full FIFO always stalls for one more cycle.
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (wbm_ack_i) begin
          state_nxt = S_GAP;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Address / remaining-word counter / wait counter
  // ---------------------------------------------------------------------
  assign push = (state == S_REQ) && wbm_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      addr_q <= {cmd_addr[31:2], 2'b00};
      rem_q  <= cmd_len;
    end else if (push) begin
      addr_q <= addr_q + 32'd4;          // wraps naturally at 2**32
      rem_q  <= rem_q - LEN_W'(1);
    end else if (timeout) begin
      rem_q  <= '0;                      // the words not yet read are dropped
    end
  end

  // The counter is cleared whenever the FSM is outside REQ. It therefore
  // always starts from zero on the first cycle of each REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != S_REQ) begin
      wait_cnt <= '0;
    end else if (!wbm_ack_i && (wait_cnt != WAIT_LAST)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // The abort is decided in the last REQ cycle. The err pulse shows in the
  // following cycle, when the FSM is already back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  // ---------------------------------------------------------------------
  // Read-data FIFO
  // ---------------------------------------------------------------------
  assign pop = rd_ready && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wbm_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign wbm_cyc_o = (state == S_REQ);
  assign wbm_stb_o = (state == S_REQ);
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = addr_q;

  assign rd_valid  = (count != '0);
  assign rd_data   = mem[rd_ptr];

  assign busy      = (state != S_IDLE);
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_wb_seq_read_master.sv
// tb_wb_seq_read_master
// ---------------------
// Directed and randomized bench for wb_seq_read_master (TIMEOUT=8, FIFO_DEPTH=4).
// The model keeps, for the current command, the next expected word address
// and the number of words still owed. It also keeps a queue of the words the
// slave has returned, in the order the consumer must receive them.
// The slave, the consumer and the model share one negedge process, so that
// every sampled value and every driven value follows a fixed order.
// The main initial block applies commands and checks end conditions at #1
// after posedge.
module tb_wb_seq_read_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [1:0]  state_dbg;

  wb_seq_read_master #(
    .FIFO_DEPTH(4),
    .LEN_W     (16),
    .TIMEOUT   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] adr_log[$];
  logic [31:0] exp_addr    = '0;
  int          words_left  = 0;
  int          done_cnt    = 0;
  int          err_cnt     = 0;
  int          reads       = 0;
  int          stb_cycles  = 0;
  int          req_cnt     = 0;
  int          ack_lat     = 1;
  int          ready_mode  = 1;   // 0 hold off, 1 always ready, 2 random
  bit          mute        = 1'b0;
  bit          noise       = 1'b0;
  bit          pop_one     = 1'b0;
  bit          last_acked  = 1'b0;
  bit          prev_done   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- slave, consumer and monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wbm_ack_i  = 1'b0;
      rd_ready   = 1'b0;
      req_cnt    = 0;
      last_acked = 1'b0;
      prev_done  = 1'b0;
    end else begin
      // consumer side: the model queue state before this cycle's push
      check("rd_valid", rd_valid, (exp_q.size() != 0));
      case (ready_mode)
        0:       rd_ready = pop_one && rd_valid;
        1:       rd_ready = 1'b1;
        default: rd_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (pop_one && rd_valid) pop_one = 1'b0;
      if (rd_ready && rd_valid && exp_q.size() != 0) begin
        check("rd_data", rd_data, exp_q.pop_front());
      end

      // completion pulses
      if (prev_done) check("busy_after_done", busy, 1'b0);
      if (done) begin
        done_cnt++;
        check("busy_with_done", busy, 1'b1);
        check("done_words_left", words_left, 0);
      end
      if (err) begin
        err_cnt++;
        check("err_cmd_ready", cmd_ready, 1'b1);
        check("err_no_done", done, 1'b0);
      end
      prev_done = done;

      // Wishbone slave
      if (last_acked) check("cyc_gap", wbm_cyc_o, 1'b0);
      if (wbm_cyc_o) begin
        stb_cycles++;
        req_cnt++;
        check("adr", wbm_adr_o, exp_addr);
        check("stb", wbm_stb_o, 1'b1);
        check("we", wbm_we_o, 1'b0);
        check("sel", wbm_sel_o, 4'hF);
        if (!mute && req_cnt >= ack_lat) begin
          check("word_owed", (words_left > 0), 1'b1);
          wbm_ack_i = 1'b1;
          wbm_dat_i = $urandom;
          exp_q.push_back(wbm_dat_i);
          adr_log.push_back(wbm_adr_o);
          exp_addr   = exp_addr + 32'd4;
          words_left = words_left - 1;
          reads++;
          last_acked = 1'b1;
        end else begin
          wbm_ack_i  = 1'b0;
          last_acked = 1'b0;
        end
      end else begin
        check("stb_idle", wbm_stb_o, 1'b0);
        req_cnt    = 0;
        last_acked = 1'b0;
        // stray acks outside a bus cycle must be ignored
        wbm_ack_i  = noise && ($urandom_range(0, 3) == 0);
        wbm_dat_i  = $urandom;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Returns at posedge+1 of the cycle after the accepting edge.
  task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    exp_addr   = a & ~32'h3;
    words_left = l;
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = l;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_addr   = $urandom;
    cmd_len    = 16'($urandom);
  endtask

  task automatic wait_end(input int budget);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    n  = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("end_within_budget", (n < budget), 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d",
             vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0, e0, r0, s0, n;
    logic [31:0] a;
    logic [15:0] l;

    // reset
    rst = 1'b1;
    idle(3);
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_stb", wbm_stb_o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    idle(2);

    // 1: three words, latency 2, consumer always ready
    ack_lat = 2; ready_mode = 1; adr_log.delete();
    d0 = done_cnt; r0 = reads;
    issue_cmd(32'h3800_0010, 16'd3);
    wait_end(200);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_reads", reads - r0, 3);
    check("t1_adr0", (adr_log.size() > 0) ? adr_log[0] : 32'hDEAD_BEEF, 32'h3800_0010);
    check("t1_adr1", (adr_log.size() > 1) ? adr_log[1] : 32'hDEAD_BEEF, 32'h3800_0014);
    check("t1_adr2", (adr_log.size() > 2) ? adr_log[2] : 32'hDEAD_BEEF, 32'h3800_0018);
    idle(3);
    check("t1_drained", rd_valid, 1'b0);

    // 2: six words into a four-entry FIFO with the consumer stalled
    ack_lat = 1; ready_mode = 0;
    d0 = done_cnt; r0 = reads;
    issue_cmd(32'h3800_0100, 16'd6);
    idle(40);
    check("t2_reads_full", reads - r0, 4);
    check("t2_busy", busy, 1'b1);
    check("t2_stall_cyc", wbm_cyc_o, 1'b0);
    pop_one = 1'b1;
    idle(1);
    check("t2_gap_after_pop", wbm_cyc_o, 1'b0);
    idle(1);
    check("t2_req_after_pop", wbm_cyc_o, 1'b1);
    idle(10);
    check("t2_reads_fifth", reads - r0, 5);
    ready_mode = 1;
    wait_end(200);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_reads_all", reads - r0, 6);
    idle(4);

    // 3: zero-length command while the FIFO holds a word
    ready_mode = 0;
    issue_cmd(32'h3800_0300, 16'd1);
    wait_end(100);
    idle(2);
    s0 = stb_cycles; d0 = done_cnt;
    issue_cmd(32'h3800_0400, 16'd0);
    check("t3_done_pulse", done, 1'b1);
    check("t3_busy", busy, 1'b1);
    idle(1);
    check("t3_done_low", done, 1'b0);
    check("t3_busy_low", busy, 1'b0);
    check("t3_cmd_ready", cmd_ready, 1'b1);
    check("t3_no_bus", stb_cycles - s0, 0);
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_fifo_kept", rd_valid, 1'b1);
    check("t3_fifo_head", rd_data, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
    ready_mode = 1;
    idle(4);

    // 4: slave never acknowledges
    noise = 1'b0; mute = 1'b1;
    d0 = done_cnt; e0 = err_cnt; r0 = reads; s0 = stb_cycles;
    issue_cmd(32'h3800_0200, 16'd3);
    wait_end(100);
    check("t4_err_once", err_cnt - e0, 1);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_stb_cycles", stb_cycles - s0, 8);
    check("t4_no_reads", reads - r0, 0);
    check("t4_cmd_ready", cmd_ready, 1'b1);
    check("t4_busy", busy, 1'b0);
    mute = 1'b0; words_left = 0;
    idle(3);
    check("t4_err_single", err_cnt - e0, 1);
    check("t4_still_idle", busy, 1'b0);

    // 5: address wrap
    adr_log.delete(); ack_lat = 1;
    issue_cmd(32'hFFFF_FFFE, 16'd2);
    wait_end(100);
    check("t5_count", adr_log.size(), 2);
    check("t5_adr0", (adr_log.size() > 0) ? adr_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("t5_adr1", (adr_log.size() > 1) ? adr_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    idle(3);

    // 6: reset during the second read of four
    ack_lat = 3; r0 = reads;
    issue_cmd(32'h3800_0500, 16'd4);
    n = 0;
    while (!(reads == r0 + 1 && wbm_cyc_o) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reach_word2", (n < 200), 1'b1);
    rst = 1'b1;
    idle(1);
    check("t6_cyc", wbm_cyc_o, 1'b0);
    check("t6_rd_valid", rd_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_adr", wbm_adr_o, 32'h0);
    rst = 1'b0; words_left = 0;
    idle(1);
    d0 = done_cnt; r0 = reads; ack_lat = 1;
    issue_cmd(32'h3800_0600, 16'd2);
    wait_end(100);
    check("t6_new_done", done_cnt - d0, 1);
    check("t6_new_reads", reads - r0, 2);
    idle(3);

    // 7: randomized commands, latencies, consumer behaviour and stray acks
    noise = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a          = $urandom;
      l          = 16'($urandom_range(0, 9));
      ack_lat    = $urandom_range(1, 4);
      ready_mode = $urandom_range(1, 2);
      d0 = done_cnt; r0 = reads;
      issue_cmd(a, l);
      wait_end(600);
      check("rand_done", done_cnt - d0, 1);
      check("rand_reads", reads - r0, int'(l));
    end
    noise = 1'b0; ready_mode = 1;
    idle(10);
    check("final_drained", rd_valid, 1'b0);
    check("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
